dcalc_deser_test: RTL

DCALC_DESER_TEST -- requirements
Module: dcalc_deser_test

---
 rtl/dcalc_test_pkg.sv | 13 +
 rtl/dcalc_deser_shift.sv | 32 +++
 rtl/dcalc_deser_test.sv | 90 +++++++++
 3 files changed

// File: rtl/dcalc_test_pkg.sv
// Shared types and constants for the serial deserializer slice.
package dcalc_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        HOLD
    } state_t;

    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/dcalc_deser_shift.sv
// Bit-addressed shift register plus bit counter for the deserializer.
module dcalc_deser_shift
    import dcalc_test_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load_en,
    input  logic             din,
    output logic [WIDTH-1:0] data,
    output logic [CW-1:0]    cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
        end else if (clr) begin
            data <= '0;
            cnt  <= '0;
        end else if (load_en) begin
            data[cnt] <= din;
            // Counter parks on the last index; the FSM leaves SHIFT there.
            if (cnt != CW'(WIDTH - 1))
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dcalc_deser_test.sv
// Serial-to-parallel deserializer: start bit, WIDTH data bits LSB first, even parity, held output.
module dcalc_deser_test
    import dcalc_test_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] sh_data;
    logic [CW-1:0]    sh_cnt;
    logic             sh_clr;
    logic             sh_load;
    logic             last_bit;

    // Nonzero means the data bits plus parity bit hold an odd number of ones.
    function automatic logic frame_parity(input logic [WIDTH-1:0] d, input logic p);
        return ^{d, p};
    endfunction

    assign sh_clr   = (state == IDLE) && sin_valid && sin;
    assign sh_load  = (state == SHIFT) && sin_valid;
    assign last_bit = (sh_cnt == CW'(WIDTH - 1));

    dcalc_deser_shift #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (sh_clr),
        .load_en (sh_load),
        .din     (sin),
        .data    (sh_data),
        .cnt     (sh_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sin_valid && sin) begin
                        state      <= SHIFT;
                        parity_err <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sin_valid && last_bit)
                        state <= PARITY;
                end
                PARITY: begin
                    if (sin_valid) begin
                        state      <= HOLD;
                        dout       <= sh_data;
                        parity_err <= frame_parity(sh_data, sin);
                        dout_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // Input line is ignored here, even on the handshake edge.
                    if (dout_ready) begin
                        state      <= IDLE;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
